// File: rtl/instruction_encoder_pkg.sv
// Shared RISC-V encoding definitions (riscv_defs): format codes, opcodes and the NOP word.
// Also imported by immediate_decoder, so keep the fmt numbering stable.
package riscv_defs;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_LI   = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } enc_state_e;

  localparam logic [6:0]  OPC_LUI       = 7'b0110111;
  localparam logic [6:0]  OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [2:0]  F3_ADDI       = 3'b000;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;

  // True when value is representable as a signed integer of the given width.
  function automatic logic fits_signed(input logic [XLEN-1:0] value, input int bits);
    logic [XLEN-1:0] upper;
    upper = $signed(value) >>> (bits - 1);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request/response bundle for instruction_encoder; master drives requests, slave is the encoder.
interface instruction_encoder_if;
  import riscv_defs::*;

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      fmt;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     instruction;
  logic            out_last;
  logic            range_err;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instruction, out_last, range_err
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instruction, out_last, range_err
  );

endinterface

// File: rtl/instruction_encoder_packer.sv
// Scatters the immediate into its RV bit positions for I/S/B/U/J and flags unrepresentable values.
// Bits outside the immediate fields are left zero so the caller can OR in register fields.
module imm_field_packer
  import riscv_defs::*;
(
  input  fmt_e            fmt_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [31:0]     imm_bits_o,
  output logic            err_o
);

  always_comb begin
    imm_bits_o = '0;
    err_o      = 1'b0;
    case (fmt_i)
      FMT_I: begin
        imm_bits_o = {imm_i[11:0], 20'd0};
        err_o      = !fits_signed(imm_i, 12);
      end
      FMT_S: begin
        imm_bits_o = {imm_i[11:5], 13'd0, imm_i[4:0], 7'd0};
        err_o      = !fits_signed(imm_i, 12);
      end
      FMT_B: begin
        imm_bits_o = {imm_i[12], imm_i[10:5], 13'd0, imm_i[4:1], imm_i[11], 7'd0};
        err_o      = !fits_signed(imm_i, 13) || imm_i[0];
      end
      FMT_U: begin
        imm_bits_o = {imm_i[31:12], 12'd0};
        err_o      = (imm_i[11:0] != 12'd0) || !fits_signed(imm_i, 32);
      end
      FMT_J: begin
        imm_bits_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'd0};
        err_o      = !fits_signed(imm_i, 21) || imm_i[0];
      end
      default: begin
        imm_bits_o = '0;
        err_o      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes decoded instruction fields back into 32-bit RV words; LI expands to LUI+ADDIW when needed.
// Output words are registered and held under backpressure; a new request may enter as the last word leaves.
module instruction_encoder
  import riscv_defs::*;
#(
  parameter int CHECK_RANGE = 1
) (
  input logic                  clk,
  input logic                  reset,
  instruction_encoder_if.slave bus
);

  localparam bit RangeOn = (CHECK_RANGE != 0);

  enc_state_e  state_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic        range_err_q;
  logic [31:0] instr_q;
  logic [31:0] word2_q;

  fmt_e        fmt;
  logic [31:0] imm_bits;
  logic        imm_err;
  logic [19:0] li_hi;
  logic [31:0] word1_d;
  logic [31:0] word2_d;
  logic        two_words_d;
  logic        err_d;
  logic        take;
  logic        accept;

  assign fmt = fmt_e'(bus.fmt);

  imm_field_packer u_packer (
    .fmt_i      (fmt),
    .imm_i      (bus.imm),
    .imm_bits_o (imm_bits),
    .err_o      (imm_err)
  );

  // Rounds the upper part so that ADDIW's sign-extended low 12 bits land on the exact value.
  assign li_hi = bus.imm[31:12] + {19'd0, bus.imm[11]};

  always_comb begin
    word1_d     = NOP_WORD;
    word2_d     = NOP_WORD;
    two_words_d = 1'b0;
    err_d       = 1'b0;
    case (fmt)
      FMT_R: word1_d = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I: begin
        word1_d = {12'd0, bus.rs1, bus.funct3, bus.rd, bus.opcode} | imm_bits;
        err_d   = imm_err;
      end
      FMT_S, FMT_B: begin
        word1_d = {7'd0, bus.rs2, bus.rs1, bus.funct3, 5'd0, bus.opcode} | imm_bits;
        err_d   = imm_err;
      end
      FMT_U, FMT_J: begin
        word1_d = {20'd0, bus.rd, bus.opcode} | imm_bits;
        err_d   = imm_err;
      end
      FMT_LI: begin
        if (fits_signed(bus.imm, 12)) begin
          word1_d = {bus.imm[11:0], 5'd0, F3_ADDI, bus.rd, OPC_OP_IMM};
        end else if (fits_signed(bus.imm, 32)) begin
          word1_d     = {li_hi, bus.rd, OPC_LUI};
          word2_d     = {bus.imm[11:0], bus.rd, F3_ADDI, bus.rd, OPC_OP_IMM_32};
          two_words_d = (bus.imm[11:0] != 12'd0);
        end else begin
          err_d = 1'b1;
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  assign take         = out_valid_q & bus.out_ready;
  assign bus.in_ready = (state_q == IDLE) | (take & out_last_q);
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      out_last_q  <= 1'b0;
      range_err_q <= 1'b0;
      word2_q     <= '0;
    end else if (accept) begin
      state_q     <= EMIT1;
      out_valid_q <= 1'b1;
      instr_q     <= word1_d;
      out_last_q  <= !two_words_d;
      range_err_q <= RangeOn & err_d;
      word2_q     <= word2_d;
    end else begin
      case (state_q)
        EMIT1: begin
          if (take) begin
            if (!out_last_q) begin
              state_q     <= EMIT2;
              instr_q     <= word2_q;
              out_last_q  <= 1'b1;
              range_err_q <= 1'b0;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        EMIT2: begin
          if (take) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.instruction = instr_q;
  assign bus.out_last    = out_last_q;
  assign bus.range_err   = range_err_q;

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter CHECK_RANGE, default 1; 1 = flag out-of-range immediates, 0 = range_err tied 0.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request present.
REQ-005 SHALL have port in_ready, output, 1, request accepted when in_valid&in_ready.
REQ-006 SHALL have port fmt, input, 3, 0=R 1=I 2=S 3=B 4=U 5=J 6=LI pseudo, 7=reserved.
REQ-007 SHALL have ports opcode (7), funct3 (3), funct7 (7), rd (5), rs1 (5), rs2 (5), all inputs, carrying instruction fields.
REQ-008 SHALL have port imm, input, 64, signed byte-offset/value as produced by the immediate decoder.
REQ-009 SHALL have port out_valid, output, 1, instruction word present.
REQ-010 SHALL have port out_ready, input, 1, consumer takes word when out_valid&out_ready.
REQ-011 SHALL have port instruction, output, 32, encoded word.
REQ-012 SHALL have port out_last, output, 1, final word of the current request.
REQ-013 SHALL have port range_err, output, 1, immediate not representable, qualified by out_valid.

Function
REQ-014 SHALL implement states IDLE, EMIT1 and EMIT2.
REQ-015 SHALL register all outputs; the first word appears 1 cycle after acceptance.
REQ-016 SHALL drive in_ready = IDLE, or (out_valid & out_ready & out_last).
REQ-017 SHALL hold instruction, out_last and range_err stable while out_valid & !out_ready.
REQ-018 SHALL pack fields in standard RV order for R/I/S/B/U/J: I imm[11:0]; S imm[11:5],imm[4:0]; B imm[12],imm[10:5],imm[4:1],imm[11]; U imm[31:12]; J imm[20],imm[10:1],imm[11],imm[19:12].
REQ-019 SHALL set range_err for these cases: I/S outside [-2048,2047]; B outside 13-bit signed or imm[0]=1; J outside 21-bit signed or imm[0]=1; U with imm[11:0]!=0 or imm outside 32-bit signed. The truncated word SHALL still be emitted.
REQ-020 SHALL handle LI with imm in [-2048,2047] as a single word, ADDI rd,x0,imm (out_last=1).
REQ-021 SHALL handle LI with imm in 32-bit signed range (outside 12-bit) using hi=(imm+0x800)[31:12] and lo=imm[11:0]. Word 1 SHALL be LUI rd,hi (out_last=0). Word 2 SHALL be ADDIW rd,rd,lo (opcode 0011011, out_last=1). Word 2 SHALL be omitted, with LUI carrying out_last=1, when lo==0.
REQ-022 SHALL treat LI outside 32-bit signed as an error: emit a single NOP 0x00000013 with range_err=1 and out_last=1.
REQ-023 SHALL treat fmt=7 as an error: emit NOP with range_err=1.
REQ-024 SHALL support back-to-back requests: a new request may be accepted in the same cycle the final word is taken, with no bubble.
REQ-025 SHALL ignore opcode/funct fields for LI; LI SHALL use rd only.

Reset
REQ-026 SHALL on reset force state IDLE, out_valid=0, instruction=0, out_last=0 and range_err=0 on the next edge.
REQ-027 SHALL abandon any request that is mid-sequence (EMIT1/EMIT2) on reset; no second word is emitted.

Structure
REQ-028 SHALL take fmt codes, opcode constants (LUI, OP_IMM, OP_IMM_32) and the NOP word from the shared riscv_defs package/header, also used by immediate_decoder.
REQ-029 SHALL place field scattering and range checks in a combinational sub-module, imm_field_packer (fmt, imm -> imm bits, err).

Verification
REQ-030 SHALL cover B: rs1=1, rs2=2, funct3=0, opcode=1100011, imm=-20 -> 0xFE2086E3, range_err=0, out_last=1.
REQ-031 SHALL cover I: rd=5, rs1=4, funct3=0, opcode=0010011, imm=50 -> 0x03220293; imm=2048 -> range_err=1.
REQ-032 SHALL cover LI: rd=10, imm=0x12345678 -> 0x12345537 then 0x6785051B, with out_last 0 then 1.
REQ-033 SHALL cover LI: rd=1, imm=0x800 -> 0x000010B7 then 0x8000809B; imm=0x5000 -> single word 0x000050B7.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles -> word stable and in_ready=0; reset asserted in EMIT2 -> out_valid=0 next cycle and no ADDIW emitted.
